// File: rtl/stg_pipe_buf.sv
// stg_pipe_buf: DEPTH-entry valid/ready FIFO used as an inter-stage pipeline buffer.
// Every output comes from a register, so no combinational path runs from the
// downstream ready to the upstream ready, and none runs from upstream data to the output.
// Optional macro STG_PIPE_PERF_EN adds saturating stall/flush event counters.
module stg_pipe_buf #(
  parameter int unsigned  DATA_W = 64,
  parameter int unsigned  DEPTH  = 2,
  localparam int unsigned CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic              iw_clk,
  input  logic              iw_rst_n,
  input  logic              iw_in_valid,
  output logic              ow_in_ready,
  input  logic [DATA_W-1:0] iw_in_data,
  output logic              ow_out_valid,
  input  logic              iw_out_ready,
  output logic [DATA_W-1:0] ow_out_data,
  input  logic              iw_flush,
  output logic [CNT_W-1:0]  ow_count
`ifdef STG_PIPE_PERF_EN
  ,
  output logic [31:0]       ow_stall_cnt,
  output logic [31:0]       ow_flush_cnt
`endif
);

  localparam int unsigned    PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];

  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              in_ready_q, in_ready_d;
  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;

  logic push_c;
  logic pop_c;

  // Handshake qualification; flush overrides both push and pop.
  assign push_c = iw_in_valid & in_ready_q & ~iw_flush;
  assign pop_c  = out_valid_q & iw_out_ready & ~iw_flush;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
  endfunction

  // Next pointers, occupancy, and the pre-computed registered head/flags.
  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;

    if (iw_flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_c) wr_ptr_d = ptr_inc(wr_ptr_q);
      if (pop_c)  rd_ptr_d = ptr_inc(rd_ptr_q);
      if (push_c && !pop_c)      count_d = count_q + CNT_W'(1);
      else if (!push_c && pop_c) count_d = count_q - CNT_W'(1);
    end

    in_ready_d  = (count_d != CNT_FULL);
    out_valid_d = (count_d != '0);

    // The new head comes from the slot being written this cycle only when
    // the buffer would otherwise hold no older entry.
    if (count_d == '0)
      out_data_d = '0;
    else if (push_c && (rd_ptr_d == wr_ptr_q))
      out_data_d = iw_in_data;
    else
      out_data_d = mem_q[rd_ptr_d];
  end

  // Control and output registers.
  always_ff @(posedge iw_clk or negedge iw_rst_n) begin
    if (!iw_rst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  // Storage array; left unreset because the head register masks stale slots.
  always_ff @(posedge iw_clk) begin
    if (push_c) mem_q[wr_ptr_q] <= iw_in_data;
  end

  assign ow_in_ready  = in_ready_q;
  assign ow_out_valid = out_valid_q;
  assign ow_out_data  = out_data_q;
  assign ow_count     = count_q;

`ifdef STG_PIPE_PERF_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] flush_cnt_q, flush_cnt_d;
  logic        stall_ev_c;
  logic        flush_ev_c;

  assign stall_ev_c = out_valid_q & ~iw_out_ready & ~iw_flush;
  assign flush_ev_c = iw_flush & (out_valid_q | iw_in_valid);

  // Saturating event counters.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (stall_ev_c && (stall_cnt_q != 32'hFFFF_FFFF)) stall_cnt_d = stall_cnt_q + 32'd1;
    if (flush_ev_c && (flush_cnt_q != 32'hFFFF_FFFF)) flush_cnt_d = flush_cnt_q + 32'd1;
  end

  // Counter registers.
  always_ff @(posedge iw_clk or negedge iw_rst_n) begin
    if (!iw_rst_n) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign ow_stall_cnt = stall_cnt_q;
  assign ow_flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_stg_pipe_buf.sv
// Bench for stg_pipe_buf: a DEPTH=2 and a DEPTH=3 instance driven from shared inputs.
// Uses directed vector tables, a streaming sequence, and random traffic checked
// against queue models.
module tb_stg_pipe_buf;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        iv;
  logic [63:0] id;
  logic        ordy;
  logic        fl;

  logic        in_ready2, out_valid2, in_ready3, out_valid3;
  logic [63:0] out_data2, out_data3;
  logic [1:0]  count2, count3;

  int n_vec = 0;
  int n_mis = 0;

  always #5 clk = ~clk;

`ifdef STG_PIPE_PERF_EN
  logic [31:0] stall2, flush2, stall3, flush3;
`endif

  stg_pipe_buf #(.DATA_W(64), .DEPTH(2)) dut2 (
    .iw_clk(clk), .iw_rst_n(rst_n),
    .iw_in_valid(iv), .ow_in_ready(in_ready2), .iw_in_data(id),
    .ow_out_valid(out_valid2), .iw_out_ready(ordy), .ow_out_data(out_data2),
    .iw_flush(fl), .ow_count(count2)
`ifdef STG_PIPE_PERF_EN
    , .ow_stall_cnt(stall2), .ow_flush_cnt(flush2)
`endif
  );

  stg_pipe_buf #(.DATA_W(64), .DEPTH(3)) dut3 (
    .iw_clk(clk), .iw_rst_n(rst_n),
    .iw_in_valid(iv), .ow_in_ready(in_ready3), .iw_in_data(id),
    .ow_out_valid(out_valid3), .iw_out_ready(ordy), .ow_out_data(out_data3),
    .iw_flush(fl), .ow_count(count3)
`ifdef STG_PIPE_PERF_EN
    , .ow_stall_cnt(stall3), .ow_flush_cnt(flush3)
`endif
  );

  typedef struct {
    logic        iv;
    logic [63:0] id;
    logic        ordy;
    logic        fl;
    logic        e_valid;
    logic [63:0] e_data;
    logic        e_ready;
    logic [1:0]  e_count;
  } vec_t;

  function automatic vec_t mk(input logic v, input logic [63:0] d, input logic r, input logic f,
                              input logic ev, input logic [63:0] ed, input logic er,
                              input logic [1:0] ec);
    vec_t t;
    t.iv = v; t.id = d; t.ordy = r; t.fl = f;
    t.e_valid = ev; t.e_data = ed; t.e_ready = er; t.e_count = ec;
    return t;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [63:0] d, input logic r, input logic f);
    iv = v; id = d; ordy = r; fl = f;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    drive(1'b0, 64'd0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic chk_dut2(input string tag, input logic ev, input logic [63:0] ed,
                          input logic er, input logic [1:0] ec);
    chk({tag, ".valid"}, 64'(out_valid2), 64'(ev));
    chk({tag, ".data"},  out_data2, ed);
    chk({tag, ".ready"}, 64'(in_ready2), 64'(er));
    chk({tag, ".count"}, 64'(count2), 64'(ec));
  endtask

  vec_t        tbl[14];
  logic [63:0] q2[$];
  logic [63:0] q3[$];
  logic [63:0] got[$];

  initial begin
    // iv  data   ordy fl | valid head  ready count
    tbl[0]  = mk(1, 64'hA,  0, 0, 1, 64'hA,  1, 2'd1);
    tbl[1]  = mk(1, 64'hB,  0, 0, 1, 64'hA,  0, 2'd2);
    tbl[2]  = mk(1, 64'hC,  0, 0, 1, 64'hA,  0, 2'd2);
    tbl[3]  = mk(1, 64'hC,  0, 0, 1, 64'hA,  0, 2'd2);
    tbl[4]  = mk(1, 64'hC,  1, 0, 1, 64'hB,  1, 2'd1);
    tbl[5]  = mk(1, 64'hC,  1, 0, 1, 64'hC,  1, 2'd1);
    tbl[6]  = mk(0, 64'h0,  1, 0, 0, 64'h0,  1, 2'd0);
    tbl[7]  = mk(1, 64'h11, 0, 0, 1, 64'h11, 1, 2'd1);
    tbl[8]  = mk(1, 64'h22, 0, 0, 1, 64'h11, 0, 2'd2);
    tbl[9]  = mk(1, 64'h55, 1, 1, 0, 64'h0,  1, 2'd0);
    tbl[10] = mk(1, 64'h66, 0, 0, 1, 64'h66, 1, 2'd1);
    tbl[11] = mk(1, 64'h77, 1, 1, 0, 64'h0,  1, 2'd0);
    tbl[12] = mk(0, 64'h0,  1, 0, 0, 64'h0,  1, 2'd0);
    tbl[13] = mk(0, 64'h0,  1, 1, 0, 64'h0,  1, 2'd0);

    // Reset values.
    do_reset();
    #1;
    chk_dut2("reset", 1'b0, 64'd0, 1'b1, 2'd0);
    chk("reset3.ready", 64'(in_ready3), 64'd1);
    chk("reset3.count", 64'(count3), 64'd0);

    // Asynchronous reset mid-cycle after two pushes.
    @(negedge clk); drive(1'b1, 64'h1234, 1'b0, 1'b0);
    @(negedge clk); drive(1'b1, 64'h5678, 1'b0, 1'b0);
    @(posedge clk); #1;
    chk("pre_arst.count", 64'(count2), 64'd2);
    #2 rst_n = 1'b0;
    #1;
    chk_dut2("arst", 1'b0, 64'd0, 1'b1, 2'd0);
    drive(1'b0, 64'd0, 1'b0, 1'b0);
    @(negedge clk); rst_n = 1'b1;

    // Directed table on the DEPTH=2 instance.
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      drive(tbl[i].iv, tbl[i].id, tbl[i].ordy, tbl[i].fl);
      @(posedge clk); #1;
      chk_dut2($sformatf("tbl%0d", i), tbl[i].e_valid, tbl[i].e_data, tbl[i].e_ready,
               tbl[i].e_count);
    end

    // DEPTH=3 stream of 1..10 with toggling downstream ready, across pointer wraps.
    do_reset();
    begin
      int tx = 0;
      int rx = 0;
      int cyc = 0;
      logic acc;
      got.delete();
      while (rx < 10 && cyc < 200) begin
        @(negedge clk);
        drive(tx < 10, 64'(tx + 1), (cyc % 2) == 0, 1'b0);
        acc = iv & in_ready3;
        if (out_valid3 && ordy) begin
          got.push_back(out_data3);
          rx++;
        end
        @(posedge clk);
        if (acc) tx++;
        cyc++;
      end
      #1;
      chk("stream.len", 64'(rx), 64'd10);
      for (int i = 0; i < got.size(); i++)
        chk($sformatf("stream.val%0d", i), got[i], 64'(i + 1));
      chk("stream.drained", 64'(count3), 64'd0);
    end

    // Random traffic against queue models on both instances.
    do_reset();
    q2.delete();
    q3.delete();
    for (int s = 0; s < 600; s++) begin
      logic v, r, f;
      logic [63:0] d;
      @(negedge clk);
      v = 1'($urandom_range(0, 3) != 0);
      r = 1'($urandom_range(0, 2) != 0);
      f = 1'($urandom_range(0, 19) == 0);
      d = {$urandom, $urandom};
      drive(v, d, r, f);
      if (f) q2.delete();
      else begin
        logic can_push;
        can_push = (q2.size() != 2);
        if (r && q2.size() != 0) void'(q2.pop_front());
        if (v && can_push) q2.push_back(d);
      end
      if (f) q3.delete();
      else begin
        logic can_push;
        can_push = (q3.size() != 3);
        if (r && q3.size() != 0) void'(q3.pop_front());
        if (v && can_push) q3.push_back(d);
      end
      @(posedge clk); #1;
      chk("rnd2.valid", 64'(out_valid2), 64'(q2.size() != 0));
      chk("rnd2.data",  out_data2, (q2.size() != 0) ? q2[0] : 64'd0);
      chk("rnd2.ready", 64'(in_ready2), 64'(q2.size() != 2));
      chk("rnd2.count", 64'(count2), 64'(q2.size()));
      chk("rnd3.valid", 64'(out_valid3), 64'(q3.size() != 0));
      chk("rnd3.data",  out_data3, (q3.size() != 0) ? q3[0] : 64'd0);
      chk("rnd3.ready", 64'(in_ready3), 64'(q3.size() != 3));
      chk("rnd3.count", 64'(count3), 64'(q3.size()));
    end

`ifdef STG_PIPE_PERF_EN
    // Stall and flush counters, then saturation.
    do_reset();
    @(negedge clk); drive(1'b1, 64'h9, 1'b0, 1'b0);
    repeat (5) begin
      @(negedge clk); drive(1'b0, 64'h0, 1'b0, 1'b0);
    end
    @(negedge clk); drive(1'b0, 64'h0, 1'b0, 1'b1);
    @(posedge clk); #1;
    chk("perf.stall", 64'(stall2), 64'd5);
    chk("perf.flush", 64'(flush2), 64'd1);
    @(negedge clk);
    drive(1'b1, 64'h3, 1'b0, 1'b0);
    force dut2.stall_cnt_q = 32'hFFFF_FFFF;
    #1 release dut2.stall_cnt_q;
    repeat (3) begin
      @(negedge clk); drive(1'b0, 64'h0, 1'b0, 1'b0);
    end
    @(posedge clk); #1;
    chk("perf.sat", 64'(stall2), 64'hFFFF_FFFF);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule

// File: doc/stg_pipe_buf.md
Name: stg_pipe_buf

Overview:
Parametrised inter-stage pipeline buffer. It replaces fixed-width stage latches driven by stall/flush with a DEPTH-entry FIFO using a valid/ready handshake.
- Carries an opaque DATA_W-bit bundle (pc, instr, decoded fields) between any two pipeline stages, e.g. ID->EX.
- Absorbs downstream back-pressure without any combinational ready path through the stage.
- Supports a single-cycle flush.

Parameters:
DATA_W, 64, width of the carried bundle in bits (>=1)
DEPTH, 2, number of buffer entries (>=1; power of two not required)
CNT_W, $clog2(DEPTH+1), width of the occupancy count (derived; not overridden)

Ports:
iw_clk  in  1  clock, all state on rising edge
iw_rst_n  in  1  reset, asynchronous, active-low
iw_in_valid  in  1  upstream presents a bundle
ow_in_ready  out  1  buffer can accept a bundle this cycle
iw_in_data  in  DATA_W  upstream bundle
ow_out_valid  out  1  head entry valid
iw_out_ready  in  1  downstream consumes head this cycle
ow_out_data  out  DATA_W  head bundle; all-zero when ow_out_valid=0
iw_flush  in  1  discard all entries and any same-cycle push
ow_count  out  CNT_W  current occupancy, 0..DEPTH

Behaviour:
- Reset (iw_rst_n=0, async assert, sync release):
  - count=0, wr_ptr=0, rd_ptr=0.
  - ow_out_valid=0, ow_in_ready=1, ow_out_data=0, ow_count=0.
  - Storage array need not be reset; output masking hides it.
  - Reset asserted mid-transfer drops all contents immediately.
- ow_in_ready = (count != DEPTH). It depends on registered state only, with no path from iw_out_ready. A full buffer does not accept a push even when a pop occurs in the same cycle.
- ow_out_valid = (count != 0).
- ow_out_data = mem[rd_ptr] when count != 0, else 0.
- ow_count = count.
- push = iw_in_valid & ow_in_ready & ~iw_flush; pop = ow_out_valid & iw_out_ready & ~iw_flush.
- Push: mem[wr_ptr] <= iw_in_data; wr_ptr advances.
- Pop: rd_ptr advances.
- Pointers wrap DEPTH-1 -> 0 explicitly; no reliance on power-of-two overflow.
- count: +1 on push only, -1 on pop only, unchanged on both or neither. count never exceeds DEPTH and never underflows.
- Latency: a push at edge N is visible on ow_out_* after edge N (1 cycle) when empty. There is no combinational bypass from iw_in_* to ow_out_*.
- Throughput: 1 bundle/cycle sustained when DEPTH>=2 and downstream is always ready. With DEPTH=1 it is 1 bundle per 2 cycles.
- Stability: while ow_out_valid=1 and iw_out_ready=0, ow_out_data and ow_out_valid hold constant.
- Flush has priority over push and pop. The next cycle has count=0, wr_ptr=rd_ptr=0 and ow_out_valid=0. Flush on an empty buffer is harmless.
- iw_in_valid while ow_in_ready=0: no effect. Upstream must hold data until accepted.

Optional Feature:
STG_PIPE_PERF_EN
- Defined:
  - Adds ports ow_stall_cnt (out, 32) and ow_flush_cnt (out, 32), both reset to 0.
  - ow_stall_cnt increments each cycle with ow_out_valid=1 & iw_out_ready=0 & ~iw_flush.
  - ow_flush_cnt increments each cycle with iw_flush=1 & (count!=0 | iw_in_valid=1).
  - Both counters saturate at 32'hFFFF_FFFF.
- Undefined: these ports and counters do not exist. Core behaviour is identical either way.

Test Plan:
1. Reset with DEPTH=2, DATA_W=64 -> ow_out_valid=0, ow_in_ready=1, ow_out_data=0, ow_count=0. Assert iw_rst_n=0 asynchronously mid-cycle after 2 pushes -> outputs return to reset values without a clock edge.
2. Push 0xA, 0xB, 0xC with iw_out_ready=0 -> after 2 edges ow_count=2, ow_in_ready=0. 0xC is not accepted. ow_out_data holds 0xA throughout.
3. From full, hold iw_in_valid with 0xC and iw_out_ready=1 -> pops 0xA, then 0xB with 0xC pushed. Output order is 0xA, 0xB, 0xC. ow_count sequence is 2,1,1,0.
4. DEPTH=3: stream 10 bundles 1..10 with iw_out_ready toggling 1,0,1,0... -> every value delivered exactly once, in order, across pointer wraps. No bundle lost or duplicated.
5. Flush with count=2 and simultaneous push 0x55 and pop -> next cycle ow_count=0, ow_out_valid=0. 0x55 never appears. The next push of 0x66 emerges 1 cycle later.
6. With STG_PIPE_PERF_EN: 5 stall cycles then 1 flush with count=1 -> ow_stall_cnt=5, ow_flush_cnt=1. Force counter to 32'hFFFF_FFFF and stall -> value stays 32'hFFFF_FFFF.
